// File: rtl/param_misr_bist.sv
// Parametrised MISR response analyser: compacts `cycles` valid words after start, then checks against golden.
// Done pulse N+1 cycles after start (plus one per z_valid gap); z_valid low simply stalls compaction.
module param_misr_bist #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  POLY  = WIDTH'('h1D),
    parameter logic [WIDTH-1:0]  SEED  = '0,
    parameter int                CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             z_valid,
    input  logic [WIDTH-1:0] z,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature,
    output logic             pass
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPACT,
        S_DONE
    } state_t;

    // Stage 0 always takes the feedback bit, whatever POLY[0] says.
    localparam logic [WIDTH-1:0] TAPS = POLY | {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        nxt = z ^ {q[WIDTH-2:0], 1'b0} ^ (TAPS & {WIDTH{q[WIDTH-1]}});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            q         <= '0;
            rem       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            signature <= '0;
            pass      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        q   <= SEED;
                        rem <= cycles;
                        if (cycles != '0) begin
                            state <= S_COMPACT;
                            busy  <= 1'b1;
                        end else begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            signature <= SEED;
                            pass      <= (SEED == golden);
                        end
                    end
                end
                S_COMPACT: begin
                    // rem is nonzero throughout COMPACT, so the decrement cannot wrap.
                    if (z_valid && (rem != '0)) begin
                        q   <= nxt;
                        rem <= rem - CNT_W'(1);
                        if (rem == CNT_W'(1)) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            signature <= nxt;
                            pass      <= (nxt == golden);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
